// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC through an IDLE/FETCH/HOLD handshake with redirect and flush.
// Optional macro PC_MISALIGN_TRAP_EN redirects misaligned next PCs to TRAP_PC instead of forcing alignment.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic [27:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t      state_r;
  logic        drop_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] sel_pc_s;
  logic [31:0] next_pc_s;
  logic        misaligned_s;

  // Next-PC selection: jr > jump > branch > sequential, then alignment handling.
  always_comb begin
    pc_plus4_s = pc + 32'd4;
    sel_pc_s   = pc_plus4_s;
    if (jr) begin
      sel_pc_s = jr_target;
    end else if (jump) begin
      sel_pc_s = {pc_plus4_s[31:28], jump_target};
    end else if (branch_taken) begin
      sel_pc_s = pc_plus4_s + branch_offset;
    end else begin
      sel_pc_s = pc_plus4_s;
    end
    misaligned_s = TRAP_EN && (sel_pc_s[1:0] != 2'b00);
    if (misaligned_s) begin
      next_pc_s = TRAP_PC;
    end else begin
      next_pc_s = {sel_pc_s[31:2], 2'b00};
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      pc            <= RESET_PC;
      drop_r        <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= 32'h0000_0000;
      instr_valid   <= 1'b0;
      instr         <= 32'h0000_0000;
      instr_pc      <= 32'h0000_0000;
      misalign_trap <= 1'b0;
      trap_addr     <= 32'h0000_0000;
    end else begin
      misalign_trap <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r  <= FETCH;
          imem_req <= 1'b1;
          if (flush) begin
            pc        <= flush_pc;
            imem_addr <= flush_pc;
          end else begin
            imem_addr <= pc;
          end
        end
        FETCH: begin
          // A flush without ack must keep the bus request stable and drop its response.
          if (flush) begin
            pc <= flush_pc;
            if (imem_ack) begin
              imem_addr <= flush_pc;
              drop_r    <= 1'b0;
            end else begin
              drop_r    <= 1'b1;
            end
          end else if (imem_ack) begin
            if (drop_r) begin
              drop_r    <= 1'b0;
              imem_addr <= pc;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state_r     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (flush) begin
            pc          <= flush_pc;
            imem_addr   <= flush_pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state_r     <= FETCH;
          end else if (instr_ready) begin
            pc          <= next_pc_s;
            imem_addr   <= next_pc_s;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            state_r     <= FETCH;
            if (misaligned_s) begin
              misalign_trap <= 1'b1;
              trap_addr     <= sel_pc_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          drop_r      <= 1'b0;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: redirect vector table plus hand sequences for
// startup, flush/drop, stall and reset corner cases. Honors PC_MISALIGN_TRAP_EN.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        jump;
  logic [27:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jr;
  logic [31:0] jr_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc;
  logic        misalign_trap;
  logic [31:0] trap_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jr(jr), .jr_target(jr_target), .flush(flush), .flush_pc(flush_pc),
    .pc(pc), .misalign_trap(misalign_trap), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        v_jr;
    logic        v_jump;
    logic        v_br;
    logic [31:0] v_jr_t;
    logic [27:0] v_j_t;
    logic [31:0] v_off;
    logic [31:0] exp_addr;
    logic        exp_trap;
    logic [31:0] exp_taddr;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  initial begin
    vecs[0] = '{32'h1000_0010, 1'b0, 1'b1, 1'b0, 32'h0, 28'h000_0400, 32'h0,         32'h1000_0400, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0,        32'hFFFF_FFF0, 32'h0000_00F4, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_0100, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 28'h000_0400, 32'h10, 32'h0000_0200, 1'b0, 32'h0};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 28'h0,        32'h0,         32'h0000_0000, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0, 28'h0AB_CDE0, 32'h40,        32'h00AB_CDE0, 1'b0, 32'h0};
    vecs[5] = '{32'h7FFF_FFF8, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0,        32'h0000_0010, 32'h8000_000C, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0, 28'h0,        32'h0,         32'h0000_0044, 1'b0, 32'h0};
    vecs[7] = '{32'hF000_0000, 1'b0, 1'b1, 1'b0, 32'h0, 28'h000_0008, 32'h0,         32'hF000_0008, 1'b0, 32'h0};
    vecs[8] = '{32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0, 28'h0,        32'hFFFF_FFFC, 32'h0000_0200, 1'b0, 32'h0};
`ifdef PC_MISALIGN_TRAP_EN
    vecs[9] = '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0202, 28'h0, 32'h0,       32'h0000_0080, 1'b1, 32'h0000_0202};
`else
    vecs[9] = '{32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0202, 28'h0, 32'h0,       32'h0000_0200, 1'b0, 32'h0};
`endif

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    jump = 1'b0; jump_target = 28'h0; branch_taken = 1'b0; branch_offset = 32'h0;
    jr = 1'b0; jr_target = 32'h0; flush = 1'b0; flush_pc = 32'h0;

    repeat (3) step();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_instr", instr, 32'h0);
    chk32("rst_instr_pc", instr_pc, 32'h0);
    chk1("rst_trap", misalign_trap, 1'b0);
    chk32("rst_trap_addr", trap_addr, 32'h0);

    // Startup: ack every request in its own cycle with decode always ready.
    reset = 1'b0;
    chk1("idle_req", imem_req, 1'b0);
    step();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("seq%0d_req", k), imem_req, (k % 2) == 0);
      if ((k % 2) == 0) begin
        chk32($sformatf("seq%0d_addr", k), imem_addr, 32'(k * 2));
      end else begin
        chk1($sformatf("seq%0d_valid", k), instr_valid, 1'b1);
        chk32($sformatf("seq%0d_instr", k), instr, 32'hA000_0000 + 32'(k - 1));
      end
      imem_ack   = imem_req;
      imem_rdata = 32'hA000_0000 + 32'(k);
      step();
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    chk32("seq_next_addr", imem_addr, 32'h0000_000C);

    // Redirect table: each vector seeds the PC with a flush+ack in FETCH.
    for (int i = 0; i < 10; i++) begin
      flush = 1'b1; flush_pc = vecs[i].start_pc; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
      step();
      flush = 1'b0; imem_ack = 1'b0;
      chk1($sformatf("v%0d_req0", i), imem_req, 1'b1);
      chk32($sformatf("v%0d_addr0", i), imem_addr, vecs[i].start_pc);
      chk1($sformatf("v%0d_valid0", i), instr_valid, 1'b0);
      imem_ack = 1'b1; imem_rdata = ~vecs[i].start_pc;
      step();
      imem_ack = 1'b0;
      chk1($sformatf("v%0d_valid1", i), instr_valid, 1'b1);
      chk32($sformatf("v%0d_instr", i), instr, ~vecs[i].start_pc);
      chk32($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].start_pc);
      chk1($sformatf("v%0d_req1", i), imem_req, 1'b0);
      instr_ready = 1'b1;
      jr = vecs[i].v_jr; jump = vecs[i].v_jump; branch_taken = vecs[i].v_br;
      jr_target = vecs[i].v_jr_t; jump_target = vecs[i].v_j_t; branch_offset = vecs[i].v_off;
      step();
      instr_ready = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      chk1($sformatf("v%0d_req2", i), imem_req, 1'b1);
      chk32($sformatf("v%0d_addr2", i), imem_addr, vecs[i].exp_addr);
      chk32($sformatf("v%0d_pc", i), pc, vecs[i].exp_addr);
      chk1($sformatf("v%0d_valid2", i), instr_valid, 1'b0);
      chk1($sformatf("v%0d_trap", i), misalign_trap, vecs[i].exp_trap);
      chk32($sformatf("v%0d_trap_addr", i), trap_addr, vecs[i].exp_taddr);
    end
    step();
    chk1("trap_pulse_end", misalign_trap, 1'b0);
    chk32("trap_addr_held", trap_addr, vecs[9].exp_taddr);

    // Flush in FETCH without ack: old request held, late response dropped.
    flush = 1'b1; flush_pc = 32'h0000_0300; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; flush_pc = 32'h0000_0080;
    step();
    flush = 1'b0;
    chk32("drop_addr_c1", imem_addr, 32'h0000_0300);
    chk1("drop_req_c1", imem_req, 1'b1);
    chk32("drop_pc_c1", pc, 32'h0000_0080);
    step();
    chk32("drop_addr_c2", imem_addr, 32'h0000_0300);
    chk1("drop_valid_c2", instr_valid, 1'b0);
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk1("drop_valid_after", instr_valid, 1'b0);
    chk1("drop_req_after", imem_req, 1'b1);
    chk32("drop_addr_after", imem_addr, 32'h0000_0080);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk1("refetch_valid", instr_valid, 1'b1);
    chk32("refetch_instr", instr, 32'h1234_5678);
    chk32("refetch_instr_pc", instr_pc, 32'h0000_0080);

    // Flush from HOLD, then two flushes while a response is outstanding.
    flush = 1'b1; flush_pc = 32'h0000_0400;
    step();
    chk1("hold_flush_valid", instr_valid, 1'b0);
    chk32("hold_flush_addr", imem_addr, 32'h0000_0400);
    flush_pc = 32'h0000_0500;
    step();
    flush_pc = 32'h0000_0600;
    step();
    flush = 1'b0;
    chk32("dbl_flush_addr", imem_addr, 32'h0000_0400);
    chk32("dbl_flush_pc", pc, 32'h0000_0600);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    chk1("dbl_drop_valid", instr_valid, 1'b0);
    chk32("dbl_drop_addr", imem_addr, 32'h0000_0600);
    imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
    step();
    imem_ack = 1'b0;
    chk1("dbl_valid", instr_valid, 1'b1);
    chk32("dbl_instr_pc", instr_pc, 32'h0000_0600);

    // Stall in HOLD: redirects and stray acks must be ignored.
    jump = 1'b1; jump_target = 28'h0FF_FF00; imem_ack = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk1($sformatf("stall%0d_valid", s), instr_valid, 1'b1);
      chk32($sformatf("stall%0d_instr", s), instr, 32'h6666_6666);
      chk32($sformatf("stall%0d_instr_pc", s), instr_pc, 32'h0000_0600);
      chk1($sformatf("stall%0d_req", s), imem_req, 1'b0);
    end
    jump = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk32("stall_next_addr", imem_addr, 32'h0000_0604);
    chk1("stall_next_req", imem_req, 1'b1);

    // Reset mid-FETCH, outranking flush; late ack in IDLE ignored.
    reset = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0900;
    step();
    reset = 1'b0; flush = 1'b0;
    chk32("mid_rst_pc", pc, 32'h0);
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_valid", instr_valid, 1'b0);
    chk32("mid_rst_instr", instr, 32'h0);
    chk32("mid_rst_trap_addr", trap_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack = 1'b0;
    chk1("late_ack_req", imem_req, 1'b1);
    chk32("late_ack_addr", imem_addr, 32'h0);
    chk1("late_ack_valid", instr_valid, 1'b0);
    step();
    chk1("late_ack_valid2", instr_valid, 1'b0);
    chk32("late_ack_addr2", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
